relogio_ctrl: RTL
=================

// Module: relogio_ctrl
// PURPOSE
//  Sequencer for the clock's seconds/minutes/hours BCD counters. Turns the 1 Hz tick plus
//  wrap flags into single-cycle increment strobes (normal run). Provides a button-driven
//  time-set mode that freezes the time base and steps hours or minutes directly.
//  Also drives display blink enables. Sits between the tick generator/buttons and the counters.
// PARAMETERS
//  BLINK_CYCLES   25_000_000  clk cycles per blink half-period in set modes
//  HOLD_CYCLES    50_000_000  btn_inc hold time before auto-repeat starts (AUTO_REPEAT_EN only)
//  REPEAT_CYCLES  12_500_000  auto-repeat period while btn_inc stays held (AUTO_REPEAT_EN only)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous reset, active-high
//  tick_1hz       in   1  one-cycle pulse, once per second
//  seg_fim        in   1  seconds counter currently at 59
//  min_fim        in   1  minutes counter currently at 59
//  btn_modo       in   1  mode button, synchronized, debounced level, 1 = pressed
//  btn_inc        in   1  increment button, synchronized, debounced level, 1 = pressed
//  incrementa_seg out  1  one-cycle strobe to seconds counter
//  incrementa_min out  1  one-cycle strobe to minutes counter
//  incrementa_hora out 1  one-cycle strobe to hours counter
//  zera_seg       out  1  one-cycle strobe: clear seconds to 00
//  modo           out  2  current mode (modo_t)
//  pisca_h        out  1  hours digits blank phase
//  pisca_m        out  1  minutes digits blank phase
// BEHAVIOUR
//  Reset (async, rst=1): modo=MODO_NORMAL; all strobes, pisca_* and blink counter 0.
//   Button history registers reset to 1: a button held through reset release gives no pulse.
//  All outputs registered; every strobe is exactly 1 cycle, 1 cycle after the causing input.
//  Button press = rising edge of btn_* (prev=0, now=1).
//  FSM on btn_modo press: NORMAL -> AJ_H -> AJ_M -> NORMAL.
//   AJ_M->NORMAL also pulses zera_seg in the same cycle as the modo update.
//  MODO_NORMAL:
//   tick_1hz -> incrementa_seg.
//   tick_1hz & seg_fim -> also incrementa_min.
//   tick_1hz & seg_fim & min_fim -> also incrementa_hora. All strobes fire in the same cycle.
//   btn_inc ignored.
//  MODO_AJ_H: tick_1hz ignored (time frozen). btn_inc press -> incrementa_hora only.
//   Hour counter wraps 23->00 by itself.
//  MODO_AJ_M: tick_1hz ignored. btn_inc press -> incrementa_min only.
//   59->00 wrap gives no hour carry (incrementa_hora stays 0).
//  Simultaneous btn_modo and btn_inc press: mode change wins; inc press discarded.
//   Any pending auto-repeat is cancelled on every mode change.
//  Blink: counter runs only in set modes; it is cleared and phase set to 0 on every mode change.
//   Phase toggles every BLINK_CYCLES. pisca_h = (modo==AJ_H)&phase; pisca_m = (modo==AJ_M)&phase.
//   Both pisca_* = 0 in NORMAL.
//   Phase forced to 0 for BLINK_CYCLES after each inc strobe, so the stepped value is visible.
//  Counters saturate-free: widths = $clog2(max param)+1; restart from 0 on release or mode change.
// CONFIGURATION
//  RELOGIO_AUTO_REPEAT_EN defined: in AJ_H/AJ_M, btn_inc held continuously behaves as follows.
//   After HOLD_CYCLES past the press, one extra strobe; then one more every REPEAT_CYCLES until release.
//  Not defined: one strobe per press only; HOLD/REPEAT parameters unused, no repeat counter built.
// STRUCTURE
//  relogio_pkg: typedef enum logic [1:0] modo_t {MODO_NORMAL=0, MODO_AJ_H=1, MODO_AJ_M=2}.
//   Encoding 3 is illegal and recovers to MODO_NORMAL.
//  Sub-module botao_pulso (one instance per button): edge detect plus optional auto-repeat.
//   Ports: clk, rst, nivel, pulso. Auto-repeat is enabled only on the btn_inc instance (parameter).
//  relogio_ctrl holds the FSM, strobe generation and blink timer.
// TESTING (bench uses BLINK_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3)
//  1. NORMAL, tick with seg_fim=1, min_fim=1 -> next cycle incrementa_seg/min/hora all 1 for 1 cycle.
//     Tick with seg_fim=0 -> only incrementa_seg.
//  2. btn_modo pressed 3x -> modo 0->1->2->0; zera_seg=1 only on the 2->0 step.
//     Ticks during modo 1/2 -> no strobes.
//  3. AJ_H, 24 btn_inc presses -> exactly 24 incrementa_hora pulses, no min/seg strobes.
//     AJ_M press with min_fim=1 -> incrementa_min only.
//  4. Same-cycle presses of btn_modo and btn_inc in AJ_H -> modo=AJ_M, no strobe.
//     rst asserted mid-hold -> all outputs 0 immediately; held buttons give no pulse after release of rst.
//  5. AJ_M idle 20 cycles -> pisca_m toggles every 4 cycles, pisca_h=0.
//     Press btn_inc -> pisca_m=0 for next 4 cycles.
//  6. RELOGIO_AUTO_REPEAT_EN: hold btn_inc 20 cycles in AJ_H -> pulses at press+1, +9, +12, +15, +18.
//     Without the macro: one pulse only.

Source files
------------

// File: rtl/relogio_pkg.sv
// relogio_pkg: mode encoding and small helpers shared by the clock sequencer.
package relogio_pkg;

   typedef enum logic [1:0] {
      MODO_NORMAL = 2'd0,
      MODO_AJ_H   = 2'd1,
      MODO_AJ_M   = 2'd2
   } modo_t;

   // Mode button cycles NORMAL -> AJ_H -> AJ_M -> NORMAL; anything else lands in NORMAL.
   function automatic modo_t prox_modo(input modo_t m);
      return (m == MODO_NORMAL) ? MODO_AJ_H : (m == MODO_AJ_H) ? MODO_AJ_M : MODO_NORMAL;
   endfunction

   function automatic int largura(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/relogio_ctrl_botao.sv
// botao_pulso: rising-edge detector for a debounced button, with optional hold-to-repeat.
// History resets to 1 so a button held through reset release produces no pulse.
module botao_pulso
   import relogio_pkg::*;
#(
   parameter bit REPEAT_EN     = 1'b0,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 12_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic nivel,
   output logic pulso
);

   logic prev_q;
   logic borda;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b1;
      else     prev_q <= nivel;
   end

   assign borda = nivel & ~prev_q;

   generate
      if (REPEAT_EN) begin : g_rep
         localparam int CW = largura((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
         localparam logic [CW-1:0] HOLD_N = CW'(HOLD_CYCLES);
         localparam logic [CW-1:0] REP_N  = CW'(REPEAT_CYCLES);
         logic [CW-1:0] cnt_q, cnt_d;
         logic          rep_q, rep_d;
         logic          dispara;
         // cnt_q == 0 means disarmed: only a real press starts the hold timer
         always_comb begin
            dispara = nivel & prev_q & (cnt_q != '0) & (cnt_q == (rep_q ? REP_N : HOLD_N));
            cnt_d   = !nivel ? '0 : (borda | dispara) ? CW'(1) : (cnt_q == '0) ? '0 : cnt_q + 1'b1;
            rep_d   = nivel & (rep_q | dispara);
         end
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q <= '0;
               rep_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               rep_q <= rep_d;
            end
         end
         assign pulso = borda | dispara;
      end else begin : g_simples
         assign pulso = borda;
      end
   endgenerate

endmodule

// File: rtl/relogio_ctrl.sv
// relogio_ctrl: mode FSM, counter increment strobes and set-mode blink timer for the clock.
// Define RELOGIO_AUTO_REPEAT_EN to enable hold-to-repeat on btn_inc in the set modes.
module relogio_ctrl
   import relogio_pkg::*;
#(
   parameter int BLINK_CYCLES  = 25_000_000,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       seg_fim,
   input  logic       min_fim,
   input  logic       btn_modo,
   input  logic       btn_inc,
   output logic       incrementa_seg,
   output logic       incrementa_min,
   output logic       incrementa_hora,
   output logic       zera_seg,
   output logic [1:0] modo,
   output logic       pisca_h,
   output logic       pisca_m
);

`ifdef RELOGIO_AUTO_REPEAT_EN
   localparam bit AUTO_REP = 1'b1;
`else
   localparam bit AUTO_REP = 1'b0;
`endif

   localparam int            BW     = largura(BLINK_CYCLES);
   localparam logic [BW-1:0] BL_FIM = BW'(BLINK_CYCLES - 1);

   logic          modo_p, inc_p, inc_ev, ajuste, limpa, fim;
   modo_t         modo_q, modo_d;
   logic          seg_q, seg_d, min_q, min_d, hora_q, hora_d, zera_q, zera_d;
   logic          ph_q, ph_d, pm_q, pm_d, fase_q, fase_d, bloq_q, bloq_d;
   logic [BW-1:0] cnt_q, cnt_d;

   botao_pulso #(
      .REPEAT_EN     (1'b0),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_modo (
      .clk   (clk),
      .rst   (rst),
      .nivel (btn_modo),
      .pulso (modo_p)
   );

   botao_pulso #(
      .REPEAT_EN     (AUTO_REP),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_inc (
      .clk   (clk),
      .rst   (rst),
      .nivel (btn_inc),
      .pulso (inc_p)
   );

   // A mode change swallows btn_inc and mutes it until released, cancelling any repeat in flight.
   always_comb begin
      bloq_d = btn_inc & (bloq_q | modo_p);
      inc_ev = inc_p & ~bloq_q & ~modo_p;
      modo_d = modo_p ? prox_modo(modo_q)
             : (modo_q == MODO_AJ_H || modo_q == MODO_AJ_M) ? modo_q : MODO_NORMAL;
      seg_d  = (modo_q == MODO_NORMAL) & tick_1hz;
      min_d  = (modo_q == MODO_NORMAL) ? tick_1hz & seg_fim : (modo_q == MODO_AJ_M) & inc_ev;
      hora_d = (modo_q == MODO_NORMAL) ? tick_1hz & seg_fim & min_fim : (modo_q == MODO_AJ_H) & inc_ev;
      zera_d = modo_p & (modo_q == MODO_AJ_M);
      ajuste = modo_d != MODO_NORMAL;
      limpa  = modo_p | inc_ev | ~ajuste;
      fim    = cnt_q == BL_FIM;
      cnt_d  = (limpa | fim) ? '0 : cnt_q + 1'b1;
      fase_d = limpa ? 1'b0 : fim ? ~fase_q : fase_q;
      ph_d   = (modo_d == MODO_AJ_H) & fase_d;
      pm_d   = (modo_d == MODO_AJ_M) & fase_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         modo_q <= MODO_NORMAL;
         seg_q  <= 1'b0;
         min_q  <= 1'b0;
         hora_q <= 1'b0;
         zera_q <= 1'b0;
         ph_q   <= 1'b0;
         pm_q   <= 1'b0;
         fase_q <= 1'b0;
         bloq_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         modo_q <= modo_d;
         seg_q  <= seg_d;
         min_q  <= min_d;
         hora_q <= hora_d;
         zera_q <= zera_d;
         ph_q   <= ph_d;
         pm_q   <= pm_d;
         fase_q <= fase_d;
         bloq_q <= bloq_d;
         cnt_q  <= cnt_d;
      end
   end

   assign incrementa_seg  = seg_q;
   assign incrementa_min  = min_q;
   assign incrementa_hora = hora_q;
   assign zera_seg        = zera_q;
   assign modo            = modo_q;
   assign pisca_h         = ph_q;
   assign pisca_m         = pm_q;

endmodule
